// File: rtl/mult_share_arbiter_if.sv
// Bundle of requester handshake and multiplier-side signals for mult_share_arbiter.
// slave = arbiter side, master = requesters plus the multiplier.
interface mult_share_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
);
  logic [N-1:0]   req;
  logic [8*N-1:0] req_dataa;
  logic [8*N-1:0] req_datab;
  logic [N-1:0]   ack;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [15:0]    rsp_product;
  logic           rsp_err;
  logic           busy;
  logic           mul_start;
  logic [7:0]     mul_dataa;
  logic [7:0]     mul_datab;
  logic           mul_done;
  logic [15:0]    mul_product;

  modport slave (
    input  req, req_dataa, req_datab, mul_done, mul_product,
    output ack, rsp_valid, rsp_id, rsp_product, rsp_err, busy,
           mul_start, mul_dataa, mul_datab
  );

  modport master (
    output req, req_dataa, req_datab, mul_done, mul_product,
    input  ack, rsp_valid, rsp_id, rsp_product, rsp_err, busy,
           mul_start, mul_dataa, mul_datab
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one sequential 8x8 multiplier among N requesters,
// with a saturating watchdog that turns a hung multiplier into an error response.
module mult_share_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset_a,
  mult_share_arbiter_if.slave  bus
);

  localparam int unsigned WDW = 8;
  localparam logic [WDW-1:0] TO_LIMIT = WDW'(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]     r_state,       w_state_nxt;
  logic [N-1:0]   r_ack,         w_ack_nxt;
  logic           r_rsp_valid,   w_rsp_valid_nxt;
  logic [IDW-1:0] r_rsp_id,      w_rsp_id_nxt;
  logic [15:0]    r_rsp_product, w_rsp_product_nxt;
  logic           r_rsp_err,     w_rsp_err_nxt;
  logic           r_busy,        w_busy_nxt;
  logic           r_mul_start,   w_mul_start_nxt;
  logic [7:0]     r_mul_dataa,   w_mul_dataa_nxt;
  logic [7:0]     r_mul_datab,   w_mul_datab_nxt;
  logic [IDW-1:0] r_id,          w_id_nxt;
  logic [IDW-1:0] r_rr_ptr,      w_rr_ptr_nxt;
  logic [WDW-1:0] r_wd,          w_wd_nxt;

  logic [7:0]     w_opa [N];
  logic [7:0]     w_opb [N];
  logic           w_any;
  logic           w_hi_found;
  logic [IDW-1:0] w_hi;
  logic [IDW-1:0] w_lo;
  logic [IDW-1:0] w_win;
  logic [7:0]     w_win_a;
  logic [7:0]     w_win_b;
  logic [WDW-1:0] w_wd_inc;
  logic           w_timeout;

  for (genvar g = 0; g < int'(N); g++) begin : g_ops
    assign w_opa[g] = bus.req_dataa[8*g+7 : 8*g];
    assign w_opb[g] = bus.req_datab[8*g+7 : 8*g];
  end

  // Winner: lowest requester above rr_ptr, else lowest requester overall (wrap).
  always_comb begin
    w_any      = |bus.req;
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_lo = IDW'(i);
        if (IDW'(i) > r_rr_ptr) begin
          w_hi       = IDW'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_win   = w_hi_found ? w_hi : w_lo;
    w_win_a = '0;
    w_win_b = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (IDW'(i) == w_win) begin
        w_win_a = w_opa[i];
        w_win_b = w_opb[i];
      end
    end
  end

  assign w_wd_inc  = (r_wd == {WDW{1'b1}}) ? r_wd : r_wd + WDW'(1);
  assign w_timeout = (w_wd_inc >= TO_LIMIT);

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    w_state_nxt       = r_state;
    w_ack_nxt         = '0;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_err_nxt     = 1'b0;
    w_mul_start_nxt   = 1'b0;
    w_rsp_id_nxt      = r_rsp_id;
    w_rsp_product_nxt = r_rsp_product;
    w_mul_dataa_nxt   = r_mul_dataa;
    w_mul_datab_nxt   = r_mul_datab;
    w_id_nxt          = r_id;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_wd_nxt          = r_wd;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_ack_nxt       = N'(1) << w_win;
          w_mul_dataa_nxt = w_win_a;
          w_mul_datab_nxt = w_win_b;
          w_id_nxt        = w_win;
          w_rr_ptr_nxt    = w_win;
          w_state_nxt     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_mul_start_nxt = 1'b1;
        w_wd_nxt        = '0;
        w_state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        w_wd_nxt = w_wd_inc;
        // A done flag arriving on the timeout cycle still counts as success.
        if (bus.mul_done) begin
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_id_nxt      = r_id;
          w_rsp_product_nxt = bus.mul_product;
          w_state_nxt       = S_RESP;
        end else if (w_timeout) begin
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_id_nxt      = r_id;
          w_rsp_product_nxt = '0;
          w_state_nxt       = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      r_state       <= S_IDLE;
      r_ack         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_product <= '0;
      r_rsp_err     <= 1'b0;
      r_busy        <= 1'b0;
      r_mul_start   <= 1'b0;
      r_mul_dataa   <= '0;
      r_mul_datab   <= '0;
      r_id          <= '0;
      r_rr_ptr      <= IDW'(N - 1);
      r_wd          <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ack         <= w_ack_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_id      <= w_rsp_id_nxt;
      r_rsp_product <= w_rsp_product_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_busy        <= w_busy_nxt;
      r_mul_start   <= w_mul_start_nxt;
      r_mul_dataa   <= w_mul_dataa_nxt;
      r_mul_datab   <= w_mul_datab_nxt;
      r_id          <= w_id_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_wd          <= w_wd_nxt;
    end
  end

  assign bus.ack         = r_ack;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_product = r_rsp_product;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.busy        = r_busy;
  assign bus.mul_start   = r_mul_start;
  assign bus.mul_dataa   = r_mul_dataa;
  assign bus.mul_datab   = r_mul_datab;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed and randomized traffic checked against a
// round-robin/arithmetic reference model, with a 5-cycle behavioural multiplier.
module tb_mult_share_arbiter;
  localparam int unsigned N       = 4;
  localparam int unsigned IDW     = 2;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset_a;

  mult_share_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  mult_share_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         mul_hang = 1'b0;
  int         mcnt     = 0;
  logic [7:0] opa [N];
  logic [7:0] opb [N];
  int         last;
  int         ack_cyc, start_cyc;
  int         id_q [$];
  logic [15:0] prod_q [$];
  bit         err_q [$];
  logic [7:0] cur_a, cur_b;

  // Multiplier model: done pulses 5 cycles after start unless hung.
  always @(negedge clk or negedge reset_a) begin
    if (!reset_a) begin
      mcnt            = 0;
      bus.mul_done    = 1'b0;
      bus.mul_product = 16'd0;
    end else begin
      bus.mul_done = 1'b0;
      if (bus.mul_start === 1'b1 && !mul_hang) begin
        mcnt = 5;
      end else if (mcnt > 0) begin
        mcnt = mcnt - 1;
        if (mcnt == 0) begin
          bus.mul_done    = 1'b1;
          bus.mul_product = 16'(bus.mul_dataa) * 16'(bus.mul_datab);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Round-robin reference: pending requester with the smallest forward distance from last grant.
  function automatic int pick(input logic [N-1:0] p, input int lst);
    int best, bd, d;
    best = -1;
    bd   = int'(N) + 1;
    for (int i = 0; i < int'(N); i++) begin
      if (p[i]) begin
        d = (i - lst - 1 + 2 * int'(N)) % int'(N);
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < int'(N); i++) begin
      bus.req_dataa[8*i +: 8] = opa[i];
      bus.req_datab[8*i +: 8] = opb[i];
    end
  endtask

  task automatic serve(input logic [N-1:0] init, input logic [N-1:0] sticky, input int ngrants);
    logic [N-1:0]   pend, reas, nreas;
    logic [IDW-1:0] wi;
    int grants, rsps, budget, w, eid;
    logic [15:0] ep;
    bit ee;
    grants = 0; rsps = 0; budget = 0; reas = '0;
    @(negedge clk);
    drive_ops();
    pend    = init;
    bus.req = pend;
    while (rsps < ngrants && budget < 2000) begin
      @(negedge clk);
      budget++;
      nreas = '0;
      if (bus.ack !== '0) begin
        w = pick(pend, last);
        chk("ack_grant", 32'(bus.ack), (w < 0) ? 32'd0 : (32'd1 << w));
        chk("busy_on_ack", 32'(bus.busy), 32'd1);
        if (w >= 0) begin
          wi     = IDW'(w);
          last   = w;
          pend   = pend & ~(N'(1) << w);
          grants++;
          id_q.push_back(w);
          prod_q.push_back(mul_hang ? 16'd0 : 16'(opa[wi]) * 16'(opb[wi]));
          err_q.push_back(mul_hang);
          cur_a   = opa[wi];
          cur_b   = opb[wi];
          ack_cyc = cyc;
          if (sticky[wi] && (grants + $countones(pend) < ngrants)) nreas = N'(1) << w;
        end
      end
      if (bus.mul_start === 1'b1) begin
        chk("start_latency", 32'(cyc - ack_cyc), 32'd1);
        chk("mul_dataa", 32'(bus.mul_dataa), 32'(cur_a));
        chk("mul_datab", 32'(bus.mul_datab), 32'(cur_b));
        start_cyc = cyc;
      end
      if (bus.rsp_valid === 1'b1) begin
        rsps++;
        if (id_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsps), 32'd0);
        end else begin
          eid = id_q.pop_front();
          ep  = prod_q.pop_front();
          ee  = err_q.pop_front();
          chk("rsp_id", 32'(bus.rsp_id), 32'(eid));
          chk("rsp_product", 32'(bus.rsp_product), 32'(ep));
          chk("rsp_err", 32'(bus.rsp_err), 32'(ee));
          chk("operand_hold", 32'(bus.mul_dataa), 32'(cur_a));
          if (ee) chk("timeout_latency", 32'(cyc - start_cyc), 32'(TIMEOUT));
        end
      end
      pend    = pend | reas;
      reas    = nreas;
      bus.req = pend;
    end
    chk("drain", 32'(rsps), 32'(ngrants));
    bus.req = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int b, cnt;
    logic [N-1:0] m;
    reset_a       = 1'b0;
    bus.req       = '0;
    bus.req_dataa = '0;
    bus.req_datab = '0;
    last          = int'(N) - 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mul_start", 32'(bus.mul_start), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_product", 32'(bus.rsp_product), 32'd0);
    chk("rst_mul_dataa", 32'(bus.mul_dataa), 32'd0);
    @(negedge clk);
    reset_a = 1'b1;

    // All four requesting with equal operands: grants 0,1,2,3.
    for (int i = 0; i < int'(N); i++) begin opa[i] = 8'd10; opb[i] = 8'd40; end
    serve(4'b1111, 4'b0000, 4);

    // Single request with max-ish operands.
    opa[0] = 8'd255; opb[0] = 8'd254;
    serve(4'b0001, 4'b0000, 1);

    // Fairness: 1 and 3 re-request continuously.
    opa[1] = 8'd12; opb[1] = 8'd13; opa[3] = 8'd200; opb[3] = 8'd3;
    serve(4'b1010, 4'b1010, 4);

    // Hung multiplier, then a normal transaction.
    mul_hang = 1'b1;
    opa[2] = 8'd3; opb[2] = 8'd5;
    serve(4'b0100, 4'b0000, 1);
    mul_hang = 1'b0;
    serve(4'b0100, 4'b0000, 1);

    // Boundary operands.
    opa[0] = 8'd0;   opb[0] = 8'd200;
    opa[1] = 8'd1;   opb[1] = 8'd255;
    opa[2] = 8'd128; opb[2] = 8'd128;
    serve(4'b0111, 4'b0000, 3);

    // Randomized traffic.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < int'(N); i++) begin
        opa[i] = 8'($urandom);
        opb[i] = 8'($urandom);
      end
      m = N'($urandom_range(1, (1 << N) - 1));
      serve(m, m, $countones(m) + int'($urandom_range(0, 4)));
    end

    // Reset in the first WAIT cycle, then check pointer and service recover.
    mul_hang = 1'b1;
    opa[0] = 8'd7; opb[0] = 8'd9;
    @(negedge clk);
    drive_ops();
    bus.req = 4'b0001;
    b = 0;
    while (bus.mul_start !== 1'b1 && b < 50) begin
      @(negedge clk);
      b++;
      if (bus.ack !== '0) bus.req = '0;
    end
    chk("rst_test_reached_wait", 32'(bus.mul_start), 32'd1);
    reset_a = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_mul_start", 32'(bus.mul_start), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    reset_a  = 1'b1;
    mul_hang = 1'b0;
    last     = int'(N) - 1;
    id_q.delete(); prod_q.delete(); err_q.delete();
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) cnt++;
    end
    chk("midrst_no_rsp", 32'(cnt), 32'd0);
    opa[0] = 8'd6;  opb[0] = 8'd7;
    opa[2] = 8'd15; opb[2] = 8'd15;
    serve(4'b0101, 4'b0000, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
